// File: rtl/serial_tx_rtl.sv
// Serial transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1),
// each bit held for CLKS_PER_BIT clocks. Single-byte valid/ready input.
module serial_tx_rtl #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [7:0] in_data,
  output logic       tx_out,
  output logic       busy
);

  localparam int CW_RAW = $clog2(CLKS_PER_BIT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == LAST);
  assign in_rdy  = (state == IDLE);
  assign busy    = (state != IDLE);

  // tx_out is loaded on the edge that enters each bit period, so the line
  // level always lines up with the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tx_out <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (in_val) begin
            state  <= START;
            shreg  <= in_data;
            cnt    <= '0;
            idx    <= '0;
            tx_out <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt    <= '0;
            state  <= DATA;
            tx_out <= shreg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (idx == 3'd7) begin
              idx    <= '0;
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              idx    <= idx + 3'd1;
              tx_out <= shreg[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            state  <= IDLE;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_rtl.sv
// Directed bench for serial_tx_rtl at CLKS_PER_BIT=4 and =1; sent bytes go to a
// scoreboard queue and are popped when the line is decoded bit by bit.
module tb_serial_tx_rtl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val4, in_val1;
  logic [7:0] in_data;
  logic       in_rdy4, tx4, busy4;
  logic       in_rdy1, tx1, busy1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_tx_rtl #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_val(in_val4), .in_rdy(in_rdy4),
    .in_data(in_data), .tx_out(tx4), .busy(busy4)
  );

  serial_tx_rtl #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_val(in_val1), .in_rdy(in_rdy1),
    .in_data(in_data), .tx_out(tx1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the first START negedge; returns at the first IDLE negedge.
  task automatic recv(input bit sel, input int cpb, input bit scramble);
    logic [7:0] b;
    logic [9:0] frame;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    b = exp_q.pop_front();
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("tx_b%0d_c%0d_byte%02h", k, c, b), sel ? tx1 : tx4, frame[k]);
        check("busy_in_frame", sel ? busy1 : busy4, 1'b1);
        check("rdy_in_frame", sel ? in_rdy1 : in_rdy4, 1'b0);
        if (scramble) in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    check("idle_tx", sel ? tx1 : tx4, 1'b1);
    check("idle_busy", sel ? busy1 : busy4, 1'b0);
    check("idle_rdy", sel ? in_rdy1 : in_rdy4, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_val4 = 1'b0; in_val1 = 1'b0; in_data = 8'h00;
    // reset held 2 cycles
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_rdy", in_rdy4, 1'b1);
    check("rst_rdy_c1", in_rdy1, 1'b1);

    // no in_val: stays idle
    @(negedge clk);
    check("idle_hold_busy", busy4, 1'b0);

    // single frame 0xA5
    in_val4 = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    check("a5_rdy_before", in_rdy4, 1'b1);
    @(negedge clk);
    in_val4 = 1'b0; in_data = 8'h00;
    recv(1'b0, 4, 1'b0);

    // back-to-back with in_val held high
    @(negedge clk);
    in_val4 = 1'b1; in_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    in_data = 8'hC3; exp_q.push_back(8'hC3);
    recv(1'b0, 4, 1'b0);
    @(negedge clk);
    in_val4 = 1'b0;
    recv(1'b0, 4, 1'b0);

    // in_data churns during the frame
    @(negedge clk);
    in_val4 = 1'b1; in_data = 8'h0F; exp_q.push_back(8'h0F);
    @(negedge clk);
    in_val4 = 1'b0;
    recv(1'b0, 4, 1'b1);

    // reset in the middle of data bit 3 of 0xFF
    @(negedge clk);
    in_val4 = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_val4 = 1'b0;
    repeat (17) @(negedge clk);
    check("ff_bit3_tx", tx4, 1'b1);
    check("ff_bit3_busy", busy4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx4, 1'b1);
    check("abort_busy", busy4, 1'b0);
    check("abort_rdy", in_rdy4, 1'b1);
    in_val4 = 1'b1; in_data = 8'h81; exp_q.push_back(8'h81);
    @(negedge clk);
    in_val4 = 1'b0;
    recv(1'b0, 4, 1'b0);

    // reset wins over a simultaneous accept
    @(negedge clk);
    rst = 1'b1; in_val4 = 1'b1; in_data = 8'h55;
    @(negedge clk);
    rst = 1'b0; in_val4 = 1'b0;
    check("rstacc_rdy", in_rdy4, 1'b1);
    check("rstacc_busy", busy4, 1'b0);
    check("rstacc_tx", tx4, 1'b1);
    @(negedge clk);
    check("rstacc_dropped", busy4, 1'b0);

    // CLKS_PER_BIT=1, 0x00: 9 low then 1 high
    in_val1 = 1'b1; in_data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clk);
    in_val1 = 1'b0;
    recv(1'b1, 1, 1'b0);
    check("c1_other_idle", busy4, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx_rtl.md
SERIAL_TX_RTL -- requirements
Module: serial_tx_rtl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_val  input  1  producer asserts when in_data holds a byte to send.
REQ-005 The block SHALL have port in_rdy  output  1  asserted when the block can accept a byte.
REQ-006 The block SHALL have port in_data  input  8  byte to transmit; sampled only on the accept edge.
REQ-007 The block SHALL have port tx_out  output  1  serial line; idle level is 1.
REQ-008 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 The block SHALL use one clock, with reset synchronous and active-high; the ports are named clk and rst.

Function
REQ-010 The block SHALL implement a four-state FSM: IDLE, START, DATA, STOP.
REQ-011 The block SHALL drive in_rdy = 1 only in IDLE, combinationally from state; in_rdy SHALL be 0 in all other states.
REQ-012 The block SHALL treat a rising edge with in_val=1 and in_rdy=1 as an accept: latch in_data into the shift register, move to START, clear the bit-period counter.
REQ-013 The block SHALL leave state unchanged in IDLE when in_val=0; in_val while in_rdy=0 SHALL be ignored, and no byte SHALL be queued.
REQ-014 The block SHALL register tx_out, with values: IDLE=1, START=0, DATA=current shift-register LSB, STOP=1.
REQ-015 The block SHALL hold each state for exactly CLKS_PER_BIT cycles, counted by a bit-period counter of width clog2(CLKS_PER_BIT+1), minimum 1.
REQ-016 The block SHALL hold tx_out=0 for exactly CLKS_PER_BIT cycles starting the cycle after the accept edge.
REQ-017 The block SHALL send DATA bits LSB first, 8 bits, each for CLKS_PER_BIT cycles; a 3-bit bit index SHALL advance and the shift register SHALL shift right at each bit-period end.
REQ-018 The block SHALL transition DATA->STOP after bit index 7 completes, and STOP->IDLE after CLKS_PER_BIT stop cycles.
REQ-019 The block SHALL make a full frame occupy exactly 10*CLKS_PER_BIT cycles; the earliest next accept SHALL be on the edge ending the first IDLE cycle, giving a minimum inter-frame gap of 1 idle cycle.
REQ-020 The block SHALL drive busy = 1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 The block SHALL not change an in-progress frame when in_data changes after the accept edge.
REQ-022 The block SHALL work correctly with CLKS_PER_BIT=1: one cycle per bit and a 10-cycle frame.

Reset
REQ-023 The block SHALL, on any edge with rst=1 and regardless of state, enter IDLE and set tx_out=1, busy=0, counter=0, bit index=0, and shift register=0.
REQ-024 The block SHALL give rst priority over an accept on the same edge; that byte SHALL be dropped and in_rdy SHALL be 1 in the following cycle.
REQ-025 The block SHALL abort and discard any frame interrupted by reset mid-frame, with no partial stop bit emitted.

Verification
REQ-026 The bench SHALL cover: rst held 2 cycles -> tx_out=1, busy=0, in_rdy=1 in the first cycle after release.
REQ-027 The bench SHALL cover: CLKS_PER_BIT=4, send 0xA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles), then in_rdy=1.
REQ-028 The bench SHALL cover: in_val held high with 0x3C then 0xC3 -> two complete frames separated by exactly 1 idle cycle; 0xC3 accepted only when in_rdy=1.
REQ-029 The bench SHALL cover: in_data changed every cycle during a 0x0F frame -> line still carries 0x0F.
REQ-030 The bench SHALL cover: rst asserted during DATA bit 3 of 0xFF -> next cycle tx_out=1, busy=0, in_rdy=1; a new send of 0x81 then completes correctly.
REQ-031 The bench SHALL cover: CLKS_PER_BIT=1, send 0x00 -> tx_out low for 9 consecutive cycles, high for 1, total frame 10 cycles.
